tree_space_arbiter: RTL and testbench

- Shares the single tree space manager (node address allocator) between NB_CLIENTS engines, e.g. insert engine, delete engine and rebalancer.
- Serializes each client's address allocation and address free requests onto the manager's req/free handshakes.
- Arbitration is round-robin within each channel, with an alloc/free policy between channels.
- Returns the allocated address to the granted client and broadcasts the tree-full status.

---
 rtl/tree_space_arbiter_pkg.sv | 10 +
 rtl/tree_space_arbiter_rr_arbiter.sv | 30 +++
 rtl/tree_space_arbiter.sv | 158 +++++++++++++++
 tb/tb_tree_space_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_space_arbiter_pkg.sv
// Shared types and constants for the tree space arbiter.
package tree_space_pkg;

    typedef enum logic [1:0] {IDLE, ALLOC, FREE} state_t;
    typedef enum logic {OP_ALLOC, OP_FREE} op_t;

    localparam int unsigned ROOT_ADDR   = 0;
    localparam int unsigned MAX_CLIENTS = 8;

endpackage

// File: rtl/tree_space_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requesting client at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NB_CLIENTS = 2,
    parameter int unsigned PTR_W      = $clog2(NB_CLIENTS)
) (
    input  logic [NB_CLIENTS-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [NB_CLIENTS-1:0] grant,
    output logic [PTR_W-1:0]      grant_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NB_CLIENTS; k++) begin
            idx = (32'(ptr) + k) % NB_CLIENTS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/tree_space_arbiter.sv
// Shares one tree space manager between NB_CLIENTS engines (alloc/free channels).
// Optional occupancy statistics: define TREE_SPACE_ARBITER_STATS_EN.
module tree_space_arbiter
    import tree_space_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 16,
    parameter int unsigned NB_CLIENTS     = 2
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NB_CLIENTS-1:0]              cli_req_valid,
    output logic [NB_CLIENTS-1:0]              cli_req_ready,
    output logic [RAM_ADDR_WIDTH-1:0]          cli_req_addr,
    input  logic [NB_CLIENTS-1:0]              cli_free_valid,
    output logic [NB_CLIENTS-1:0]              cli_free_ready,
    input  logic [NB_CLIENTS*RAM_ADDR_WIDTH-1:0] cli_free_addr,
    output logic                               cli_full,
    output logic                               mgr_req_valid,
    input  logic                               mgr_req_ready,
    input  logic [RAM_ADDR_WIDTH-1:0]          mgr_req_addr,
    output logic                               mgr_free_valid,
    input  logic                               mgr_free_ready,
    output logic [RAM_ADDR_WIDTH-1:0]          mgr_free_addr,
    input  logic                               mgr_full
`ifdef TREE_SPACE_ARBITER_STATS_EN
    ,
    output logic [RAM_ADDR_WIDTH:0]            stat_occupancy,
    output logic                               stat_err
`endif
);

    localparam int unsigned PTR_W = $clog2(NB_CLIENTS);
    localparam int unsigned W     = RAM_ADDR_WIDTH;

    state_t                  state;
    op_t                     last_op;
    logic [NB_CLIENTS-1:0]   grant;
    logic [PTR_W-1:0]        grant_idx;
    logic [PTR_W-1:0]        rr_alloc;
    logic [PTR_W-1:0]        rr_free;
    logic [PTR_W-1:0]        next_ptr;

    logic [NB_CLIENTS-1:0]   alloc_cand;
    logic [NB_CLIENTS-1:0]   alloc_grant;
    logic [NB_CLIENTS-1:0]   free_grant;
    logic [PTR_W-1:0]        alloc_idx;
    logic [PTR_W-1:0]        free_idx;
    logic                    pick_alloc;
    logic                    pick_free;

    assign alloc_cand = mgr_full ? '0 : cli_req_valid;

    rr_arbiter #(.NB_CLIENTS(NB_CLIENTS)) u_alloc_arb (
        .req       (alloc_cand),
        .ptr       (rr_alloc),
        .grant     (alloc_grant),
        .grant_idx (alloc_idx)
    );

    rr_arbiter #(.NB_CLIENTS(NB_CLIENTS)) u_free_arb (
        .req       (cli_free_valid),
        .ptr       (rr_free),
        .grant     (free_grant),
        .grant_idx (free_idx)
    );

    // Both channels pending: free wins when full, otherwise alternate against last_op.
    always_comb begin
        pick_alloc = 1'b0;
        pick_free  = 1'b0;
        if (|cli_free_valid && |alloc_cand) begin
            if (mgr_full || last_op == OP_ALLOC) pick_free  = 1'b1;
            else                                 pick_alloc = 1'b1;
        end else begin
            pick_free  = |cli_free_valid;
            pick_alloc = |alloc_cand;
        end
    end

    assign next_ptr       = (grant_idx == PTR_W'(NB_CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
    assign cli_req_ready  = (state == ALLOC && mgr_req_ready)  ? grant : '0;
    assign cli_free_ready = (state == FREE  && mgr_free_ready) ? grant : '0;
    assign cli_req_addr   = mgr_req_addr;
    assign cli_full       = mgr_full;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            last_op        <= OP_FREE;
            grant          <= '0;
            grant_idx      <= '0;
            rr_alloc       <= '0;
            rr_free        <= '0;
            mgr_req_valid  <= 1'b0;
            mgr_free_valid <= 1'b0;
            mgr_free_addr  <= RAM_ADDR_WIDTH'(ROOT_ADDR);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_free) begin
                        state          <= FREE;
                        grant          <= free_grant;
                        grant_idx      <= free_idx;
                        mgr_free_valid <= 1'b1;
                        mgr_free_addr  <= cli_free_addr[free_idx*W +: W];
                    end else if (pick_alloc) begin
                        state         <= ALLOC;
                        grant         <= alloc_grant;
                        grant_idx     <= alloc_idx;
                        mgr_req_valid <= 1'b1;
                    end
                end
                ALLOC: begin
                    if (mgr_req_ready) begin
                        state         <= IDLE;
                        mgr_req_valid <= 1'b0;
                        last_op       <= OP_ALLOC;
                        rr_alloc      <= next_ptr;
                        grant         <= '0;
                    end
                end
                FREE: begin
                    if (mgr_free_ready) begin
                        state          <= IDLE;
                        mgr_free_valid <= 1'b0;
                        last_op        <= OP_FREE;
                        rr_free        <= next_ptr;
                        grant          <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TREE_SPACE_ARBITER_STATS_EN
    localparam logic [RAM_ADDR_WIDTH:0] OCC_MAX = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};

    logic alloc_hs;
    logic free_hs;

    assign alloc_hs = (state == ALLOC) && mgr_req_ready;
    assign free_hs  = (state == FREE)  && mgr_free_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_occupancy <= '0;
            stat_err       <= 1'b0;
        end else if (alloc_hs) begin
            if (stat_occupancy != OCC_MAX) stat_occupancy <= stat_occupancy + 1'b1;
        end else if (free_hs) begin
            if (stat_occupancy == '0) stat_err       <= 1'b1;
            else                      stat_occupancy <= stat_occupancy - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tree_space_arbiter.sv
// Self-checking bench for tree_space_arbiter: directed scenarios plus randomized run vs. a reference model.
module tb_tree_space_arbiter;

    localparam int W = 16;
    localparam int N = 2;

    logic             aclk;
    logic             aresetn;
    logic [N-1:0]     cli_req_valid;
    logic [N-1:0]     cli_req_ready;
    logic [W-1:0]     cli_req_addr;
    logic [N-1:0]     cli_free_valid;
    logic [N-1:0]     cli_free_ready;
    logic [N*W-1:0]   cli_free_addr;
    logic             cli_full;
    logic             mgr_req_valid;
    logic             mgr_req_ready;
    logic [W-1:0]     mgr_req_addr;
    logic             mgr_free_valid;
    logic             mgr_free_ready;
    logic [W-1:0]     mgr_free_addr;
    logic             mgr_full;
`ifdef TREE_SPACE_ARBITER_STATS_EN
    logic [W:0]       stat_occupancy;
    logic             stat_err;
`endif

    int checks = 0;
    int errors = 0;

    tree_space_arbiter #(.RAM_ADDR_WIDTH(W), .NB_CLIENTS(N)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cli_req_valid  (cli_req_valid),
        .cli_req_ready  (cli_req_ready),
        .cli_req_addr   (cli_req_addr),
        .cli_free_valid (cli_free_valid),
        .cli_free_ready (cli_free_ready),
        .cli_free_addr  (cli_free_addr),
        .cli_full       (cli_full),
        .mgr_req_valid  (mgr_req_valid),
        .mgr_req_ready  (mgr_req_ready),
        .mgr_req_addr   (mgr_req_addr),
        .mgr_free_valid (mgr_free_valid),
        .mgr_free_ready (mgr_free_ready),
        .mgr_free_addr  (mgr_free_addr),
        .mgr_full       (mgr_full)
`ifdef TREE_SPACE_ARBITER_STATS_EN
        ,
        .stat_occupancy (stat_occupancy),
        .stat_err       (stat_err)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        cli_req_valid  = '0;
        cli_free_valid = '0;
        cli_free_addr  = '0;
        mgr_req_ready  = 1'b0;
        mgr_req_addr   = '0;
        mgr_free_ready = 1'b0;
        mgr_full       = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        aresetn        = 1'b0;
        cli_req_valid  = '1;
        cli_free_valid = '1;
        cli_free_addr  = {16'h1234, 16'h5678};
        mgr_req_ready  = 1'b1;
        mgr_free_ready = 1'b1;
        mgr_full       = 1'b1;
        #3;
        checks++; if (mgr_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mgr_req_valid: got %b expected 0", mgr_req_valid); end
        checks++; if (mgr_free_valid !== 1'b0) begin errors++; $display("FAIL reset_mgr_free_valid: got %b expected 0", mgr_free_valid); end
        checks++; if (mgr_free_addr !== 16'h0000) begin errors++; $display("FAIL reset_mgr_free_addr: got %h expected 0000", mgr_free_addr); end
        checks++; if (cli_req_ready !== 2'b00) begin errors++; $display("FAIL reset_cli_req_ready: got %b expected 00", cli_req_ready); end
        checks++; if (cli_free_ready !== 2'b00) begin errors++; $display("FAIL reset_cli_free_ready: got %b expected 00", cli_free_ready); end
        checks++; if (cli_full !== 1'b1) begin errors++; $display("FAIL reset_cli_full: got %b expected 1", cli_full); end
        @(posedge aclk); #1;
        checks++; if (mgr_req_valid !== 1'b0 || mgr_free_valid !== 1'b0) begin errors++; $display("FAIL reset_held: got %b%b expected 00", mgr_req_valid, mgr_free_valid); end
`ifdef TREE_SPACE_ARBITER_STATS_EN
        checks++; if (stat_occupancy !== '0 || stat_err !== 1'b0) begin errors++; $display("FAIL reset_stats: got %h/%b expected 0/0", stat_occupancy, stat_err); end
`endif
        do_reset();
    endtask

    task automatic test_single_alloc();
        do_reset();
        @(negedge aclk);
        cli_req_valid = 2'b01; mgr_req_ready = 1'b1; mgr_req_addr = 16'h0005;
        #1;
        checks++; if (mgr_req_valid !== 1'b0) begin errors++; $display("FAIL single_cycle0_valid: got %b expected 0", mgr_req_valid); end
        @(negedge aclk); #1;
        checks++; if (mgr_req_valid !== 1'b1) begin errors++; $display("FAIL single_cycle1_valid: got %b expected 1", mgr_req_valid); end
        checks++; if (cli_req_ready !== 2'b01) begin errors++; $display("FAIL single_cli_ready: got %b expected 01", cli_req_ready); end
        checks++; if (cli_req_addr !== 16'h0005) begin errors++; $display("FAIL single_cli_addr: got %h expected 0005", cli_req_addr); end
        cli_req_valid = 2'b00;
        @(negedge aclk); #1;
        checks++; if (mgr_req_valid !== 1'b0 || cli_req_ready !== 2'b00) begin errors++; $display("FAIL single_back_idle: got %b/%b expected 0/00", mgr_req_valid, cli_req_ready); end
    endtask

    task automatic test_round_robin();
        int served;
        int c0_cnt;
        logic [W-1:0] c0_addr [2];
        logic [N-1:0] exp_g;
        do_reset();
        served = 0; c0_cnt = 0; c0_addr[0] = '1; c0_addr[1] = '1;
        @(negedge aclk);
        cli_req_valid = 2'b11; mgr_req_ready = 1'b1; mgr_req_addr = '0;
        for (int c = 0; c < 12 && served < 4; c++) begin
            #1;
            if (cli_req_ready !== 2'b00) begin
                exp_g = (served % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (cli_req_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", served, cli_req_ready, exp_g); end
                checks++; if (cli_req_addr !== W'(served)) begin errors++; $display("FAIL rr_addr%0d: got %h expected %h", served, cli_req_addr, W'(served)); end
                if (cli_req_ready[0] && c0_cnt < 2) begin c0_addr[c0_cnt] = cli_req_addr; c0_cnt++; end
                served++;
            end
            @(negedge aclk);
            mgr_req_addr = W'(served);
        end
        cli_req_valid = 2'b00;
        checks++; if (served !== 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", served); end
        checks++; if (c0_cnt !== 2 || c0_addr[0] !== 16'h0000 || c0_addr[1] !== 16'h0002) begin
            errors++; $display("FAIL rr_client0_addrs: got %0d:%h,%h expected 2:0000,0002", c0_cnt, c0_addr[0], c0_addr[1]);
        end
    endtask

    task automatic test_alternation();
        int ops;
        logic exp_alloc;
        do_reset();
        ops = 0;
        @(negedge aclk);
        cli_req_valid = 2'b01; cli_free_valid = 2'b10;
        cli_free_addr[W +: W] = 16'h0010;
        mgr_req_ready = 1'b1; mgr_free_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (cli_req_ready !== 2'b00 || cli_free_ready !== 2'b00) begin
                exp_alloc = (ops % 2 == 0);
                checks++; if (cli_req_ready !== (exp_alloc ? 2'b01 : 2'b00) || cli_free_ready !== (exp_alloc ? 2'b00 : 2'b10)) begin
                    errors++; $display("FAIL alt_op%0d: got req=%b free=%b expected %s", ops, cli_req_ready, cli_free_ready, exp_alloc ? "alloc" : "free");
                end
                if (!exp_alloc) begin
                    checks++; if (mgr_free_addr !== 16'h0010) begin errors++; $display("FAIL alt_free_addr%0d: got %h expected 0010", ops, mgr_free_addr); end
                end
                ops++;
            end
            @(negedge aclk);
        end
        cli_req_valid = '0; cli_free_valid = '0;
        checks++; if (ops !== 6) begin errors++; $display("FAIL alt_count: got %0d expected 6", ops); end
    endtask

    task automatic test_full();
        logic done;
        do_reset();
        @(negedge aclk);
        mgr_full = 1'b1; cli_req_valid = 2'b11; mgr_req_ready = 1'b1; mgr_free_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (mgr_req_valid !== 1'b0 || cli_full !== 1'b1) begin errors++; $display("FAIL full_blocked%0d: got valid=%b full=%b expected 0/1", c, mgr_req_valid, cli_full); end
            @(negedge aclk);
        end
        cli_free_valid = 2'b01; cli_free_addr[0 +: W] = 16'h0022;
        done = 1'b0;
        for (int c = 0; c < 6 && !done; c++) begin
            #1;
            checks++; if (cli_req_ready !== 2'b00) begin errors++; $display("FAIL full_no_alloc%0d: got %b expected 00", c, cli_req_ready); end
            if (cli_free_ready !== 2'b00) begin
                checks++; if (cli_free_ready !== 2'b01 || mgr_free_addr !== 16'h0022) begin errors++; $display("FAIL full_free: got %b/%h expected 01/0022", cli_free_ready, mgr_free_addr); end
                done = 1'b1;
                cli_free_valid = 2'b00;
            end
            @(negedge aclk);
        end
        checks++; if (!done) begin errors++; $display("FAIL full_free_timeout: got none expected free completion"); end
        mgr_full = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 6 && !done; c++) begin
            #1;
            if (cli_req_ready !== 2'b00) begin
                checks++; if (cli_req_ready !== 2'b01) begin errors++; $display("FAIL full_alloc_after: got %b expected 01", cli_req_ready); end
                done = 1'b1;
                cli_req_valid = 2'b00;
            end
            @(negedge aclk);
        end
        checks++; if (!done) begin errors++; $display("FAIL full_alloc_timeout: got none expected alloc completion"); end
        cli_req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge aclk);
        cli_req_valid = 2'b01; mgr_req_ready = 1'b0; mgr_req_addr = 16'hbeef;
        @(negedge aclk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (mgr_req_valid !== 1'b1 || cli_req_ready !== 2'b00) begin errors++; $display("FAIL bp_wait%0d: got %b/%b expected 1/00", c, mgr_req_valid, cli_req_ready); end
            @(negedge aclk);
        end
        mgr_req_ready = 1'b1;
        #1;
        checks++; if (cli_req_ready !== 2'b01 || cli_req_addr !== 16'hbeef) begin errors++; $display("FAIL bp_complete: got %b/%h expected 01/beef", cli_req_ready, cli_req_addr); end
        cli_req_valid = 2'b00;
        @(negedge aclk); #1;
        checks++; if (mgr_req_valid !== 1'b0 || cli_req_ready !== 2'b00) begin errors++; $display("FAIL bp_single: got %b/%b expected 0/00", mgr_req_valid, cli_req_ready); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge aclk);
        cli_free_valid = 2'b01; cli_free_addr[0 +: W] = 16'h0033; mgr_free_ready = 1'b0;
        @(negedge aclk); #1;
        checks++; if (mgr_free_valid !== 1'b1 || mgr_free_addr !== 16'h0033) begin errors++; $display("FAIL rstmid_in_free: got %b/%h expected 1/0033", mgr_free_valid, mgr_free_addr); end
        #2;
        aresetn = 1'b0;
        mgr_free_ready = 1'b1;
        #1;
        checks++; if (mgr_free_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", mgr_free_valid); end
        checks++; if (cli_free_ready !== 2'b00) begin errors++; $display("FAIL rstmid_no_ready: got %b expected 00", cli_free_ready); end
        checks++; if (mgr_free_addr !== 16'h0000) begin errors++; $display("FAIL rstmid_addr: got %h expected 0000", mgr_free_addr); end
`ifdef TREE_SPACE_ARBITER_STATS_EN
        checks++; if (stat_occupancy !== '0) begin errors++; $display("FAIL rstmid_occ: got %h expected 0", stat_occupancy); end
`endif
        cli_free_valid = 2'b00;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk); #1;
        checks++; if (mgr_free_valid !== 1'b0 || mgr_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b/%b expected 0/0", mgr_free_valid, mgr_req_valid); end
    endtask

    // Reference: first requester at or after ptr, wrapping around the client ring.
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_random();
        int m_busy;          // 0 none, 1 alloc in flight, 2 free in flight
        int m_cli;
        bit m_last_alloc;
        int m_rr_a;
        int m_rr_f;
        logic [W-1:0] m_free_addr;
        int occ;
        bit occ_err;
        logic [N-1:0] req_done;
        logic [N-1:0] free_done;
        logic [N-1:0] exp_rr;
        logic [N-1:0] exp_fr;
        logic [N-1:0] acand;
        bit use_free;
        do_reset();
        m_busy = 0; m_cli = 0; m_last_alloc = 0; m_rr_a = 0; m_rr_f = 0; m_free_addr = '0;
        occ = 0; occ_err = 0; req_done = '0; free_done = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge aclk);
            for (int i = 0; i < N; i++) begin
                if (req_done[i]) cli_req_valid[i] = 1'b0;
                else if (!cli_req_valid[i] && $urandom_range(3) == 0) cli_req_valid[i] = 1'b1;
                if (free_done[i]) cli_free_valid[i] = 1'b0;
                else if (!cli_free_valid[i] && $urandom_range(3) == 0) begin
                    cli_free_valid[i] = 1'b1;
                    cli_free_addr[i*W +: W] = W'($urandom);
                end
            end
            mgr_req_ready  = ($urandom_range(2) != 0);
            mgr_free_ready = ($urandom_range(2) != 0);
            mgr_full       = ($urandom_range(4) == 0);
            mgr_req_addr   = W'($urandom);
            #1;
            exp_rr = '0; exp_fr = '0;
            if (m_busy == 1 && mgr_req_ready)  exp_rr[m_cli] = 1'b1;
            if (m_busy == 2 && mgr_free_ready) exp_fr[m_cli] = 1'b1;
            checks++; if (mgr_req_valid !== (m_busy == 1)) begin errors++; $display("FAIL rnd_mgr_req_valid@%0d: got %b expected %b", cyc, mgr_req_valid, m_busy == 1); end
            checks++; if (mgr_free_valid !== (m_busy == 2)) begin errors++; $display("FAIL rnd_mgr_free_valid@%0d: got %b expected %b", cyc, mgr_free_valid, m_busy == 2); end
            checks++; if (mgr_free_addr !== m_free_addr) begin errors++; $display("FAIL rnd_mgr_free_addr@%0d: got %h expected %h", cyc, mgr_free_addr, m_free_addr); end
            checks++; if (cli_req_ready !== exp_rr) begin errors++; $display("FAIL rnd_cli_req_ready@%0d: got %b expected %b", cyc, cli_req_ready, exp_rr); end
            checks++; if (cli_free_ready !== exp_fr) begin errors++; $display("FAIL rnd_cli_free_ready@%0d: got %b expected %b", cyc, cli_free_ready, exp_fr); end
            checks++; if (cli_full !== mgr_full) begin errors++; $display("FAIL rnd_cli_full@%0d: got %b expected %b", cyc, cli_full, mgr_full); end
            if (exp_rr != '0) begin
                checks++; if (cli_req_addr !== mgr_req_addr) begin errors++; $display("FAIL rnd_cli_req_addr@%0d: got %h expected %h", cyc, cli_req_addr, mgr_req_addr); end
            end
`ifdef TREE_SPACE_ARBITER_STATS_EN
            checks++; if (stat_occupancy !== (W+1)'(occ) || stat_err !== occ_err) begin errors++; $display("FAIL rnd_stats@%0d: got %0d/%b expected %0d/%b", cyc, stat_occupancy, stat_err, occ, occ_err); end
`endif
            req_done = exp_rr; free_done = exp_fr;
            if (m_busy == 1) begin
                if (mgr_req_ready) begin
                    m_busy = 0; m_last_alloc = 1; m_rr_a = (m_cli + 1) % N;
                    if (occ < (1 << W)) occ++;
                end
            end else if (m_busy == 2) begin
                if (mgr_free_ready) begin
                    m_busy = 0; m_last_alloc = 0; m_rr_f = (m_cli + 1) % N;
                    if (occ == 0) occ_err = 1; else occ--;
                end
            end else begin
                acand = mgr_full ? '0 : cli_req_valid;
                if (acand != '0 && cli_free_valid != '0) use_free = mgr_full || m_last_alloc;
                else                                     use_free = (cli_free_valid != '0);
                if (use_free) begin
                    m_busy = 2; m_cli = pick(cli_free_valid, m_rr_f);
                    m_free_addr = cli_free_addr[m_cli*W +: W];
                end else if (acand != '0) begin
                    m_busy = 1; m_cli = pick(acand, m_rr_a);
                end
            end
        end
        @(negedge aclk);
        clear_inputs();
    endtask

    initial begin
        aresetn = 1'b0;
        clear_inputs();
        test_reset();
        test_single_alloc();
        test_round_robin();
        test_alternation();
        test_full();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
